dpe_csa_accum_ctrl: RTL and testbench

Sequences the combinational CSA_8 reduction tree to compute long dot-product partial sums. A job spans num_beats input vectors; each accepted beat is driven onto the CSA inputs and the CSA sum is folded into a WIDTH-bit accumulator. The final sum is presented on a valid/ready output. The block sits between the DPE input staging buffer and the DPE result path, and owns the single shared CSA_8 instance.

---
 rtl/dpe_csa_accum_ctrl.sv | 85 ++++++++
 tb/tb_dpe_csa_accum_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dpe_csa_accum_ctrl.sv
// dpe_csa_accum_ctrl: sequences the shared CSA_8 tree and folds each beat's sum into a job accumulator.
// Optional build macro DPE_ACC_SAT_EN: saturating accumulation instead of wrap-around.
module dpe_csa_accum_ctrl #(
    parameter int INPUT_VEC_LEN = 8,
    parameter int WIDTH         = 16,
    parameter int LEN_W         = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [LEN_W-1:0]               num_beats,
    output logic                           busy,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [INPUT_VEC_LEN*WIDTH-1:0] in_data,
    output logic [INPUT_VEC_LEN*WIDTH-1:0] csa_in,
    input  logic [WIDTH-1:0]               csa_s,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_sum
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, acc_add;
    logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;

`ifdef DPE_ACC_SAT_EN
    logic [WIDTH:0] sum_w;
    assign sum_w   = {1'b0, acc_q} + {1'b0, csa_s};
    assign acc_add = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
`else
    assign acc_add = acc_q + csa_s;
`endif

    assign busy      = state_q != IDLE;
    assign in_ready  = state_q == ACCUM;
    assign out_valid = state_q == DONE;
    assign out_sum   = acc_q;
    assign csa_in    = (in_ready && in_valid) ? in_data : '0;

    // Next-state: job start in IDLE, beat accumulation in ACCUM, result handshake in DONE
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = num_beats;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = (num_beats == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = acc_add;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q + LEN_W'(1) == len_q) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end
endmodule

// File: tb/tb_dpe_csa_accum_ctrl.sv
// tb_dpe_csa_accum_ctrl: scoreboard bench with an external CSA_8 model and a job-level sum reference.
module tb_dpe_csa_accum_ctrl;
    localparam int N = 8;
    localparam int W = 16;
    localparam int L = 8;

    logic           clk = 0;
    logic           rst, start, in_valid, out_ready;
    logic [L-1:0]   num_beats;
    logic           busy, in_ready, out_valid;
    logic [N*W-1:0] in_data, csa_in;
    logic [W-1:0]   csa_s, out_sum;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0]   exp_q[$];
    logic [N*W-1:0] beats[$];

    always #5 clk = ~clk;

    dpe_csa_accum_ctrl #(.INPUT_VEC_LEN(N), .WIDTH(W), .LEN_W(L)) dut (
        .clk(clk), .rst(rst), .start(start), .num_beats(num_beats), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .csa_in(csa_in),
        .csa_s(csa_s), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
    );

    // CSA_8 stand-in: lane sum truncated to W bits
    always_comb begin
        csa_s = '0;
        for (int j = 0; j < N; j++) csa_s = csa_s + csa_in[j*W +: W];
    end

    task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle a result is presented it must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: got %h expected none", out_sum);
            end else begin
                check("out_sum", out_sum, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic make_const(input int n, input logic [W-1:0] v);
        logic [N*W-1:0] b;
        beats.delete();
        for (int j = 0; j < N; j++) b[j*W +: W] = v;
        for (int i = 0; i < n; i++) beats.push_back(b);
    endtask

    task automatic make_rand(input int n);
        logic [N*W-1:0] b;
        beats.delete();
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < N; j++) b[j*W +: W] = W'($urandom);
            beats.push_back(b);
        end
    endtask

    // Reference: plain integer sum of all lanes of all beats, wrapped or clamped
    function automatic logic [W-1:0] ref_sum();
        int unsigned acc = 0;
        foreach (beats[i]) begin
            int unsigned bs = 0;
            for (int j = 0; j < N; j++) bs += beats[i][j*W +: W];
            bs = bs % (1 << W);
`ifdef DPE_ACC_SAT_EN
            acc = (acc + bs > (1 << W) - 1) ? (1 << W) - 1 : acc + bs;
`else
            acc = (acc + bs) % (1 << W);
`endif
        end
        return acc[W-1:0];
    endfunction

    task automatic run_job(input int gap, input int hold);
        int n = beats.size();
        exp_q.push_back(ref_sum());
        start = 1;
        num_beats = L'(n);
        step();
        start = 0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 0;
                in_data = {$urandom, $urandom, $urandom, $urandom};
                @(negedge clk);
                check("stall_csa_in", csa_in, 0);
                check("stall_in_ready", in_ready, 1);
                check("stall_busy", busy, 1);
                step();
            end
            in_valid = 1;
            in_data = beats[i];
            @(negedge clk);
            check("beat_in_ready", in_ready, 1);
            check("beat_csa_in", csa_in, beats[i]);
            step();
        end
        in_valid = 1;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        check("done_out_valid", out_valid, 1);
        check("done_in_ready", in_ready, 0);
        check("done_csa_in", csa_in, 0);
        step();
        in_valid = 0;
        for (int h = 0; h < hold; h++) begin
            start = 1;
            num_beats = 8'd3;
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_busy", busy, 1);
            step();
        end
        out_ready = 1;
        start = 1;
        num_beats = 8'd3;
        step();
        out_ready = 0;
        start = 0;
        @(negedge clk);
        check("idle_out_valid", out_valid, 0);
        check("idle_busy", busy, 0);
        step();
    endtask

    initial begin
        logic [N*W-1:0] b;
        rst = 1; start = 0; num_beats = '0; in_valid = 0; in_data = '0; out_ready = 0;
        step();
        step();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        step();
        rst = 0;
        step();

        for (int j = 0; j < N; j++) b[j*W +: W] = W'(j + 1);
        beats.delete();
        beats.push_back(b);
        run_job(0, 0);

        make_const(3, 16'h0100);
        run_job(2, 0);

        make_const(2, 16'h1000);
        run_job(0, 0);

        make_rand(1);
        run_job(0, 5);

        beats.delete();
        run_job(0, 1);

        make_const(4, 16'h0123);
        start = 1;
        num_beats = 8'd4;
        step();
        start = 0;
        in_valid = 1;
        in_data = beats[0];
        step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_sum", out_sum, 0);
        check("abort_csa_in", csa_in, 0);
        step();
        in_valid = 0;
        make_const(1, 16'd2);
        run_job(0, 0);

        make_rand(255);
        run_job(0, 0);

        for (int k = 0; k < 20; k++) begin
            make_rand($urandom_range(0, 6));
            run_job($urandom_range(0, 2), $urandom_range(0, 3));
        end

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_results: got %0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
